// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer
// UART transmit engine. It accepts a parallel word with a one-cycle valid strobe.
// It frames the word as:
//   start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, stop bit (1).
// Each bit is held for a programmable number of clock cycles.
// The configuration (parity enable/type, prescale) is captured together with the data.
// Changes on the config inputs during a frame therefore never disturb the frame.
// TX_OUT and Busy come straight from flops, so there is no combinational path
// from any input to an output.

module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // Width of the data bit selector; at least one bit even for degenerate widths.
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    par_en_reg;
    logic                    par_typ_reg;
    // Prescale is stored as (cycles per bit - 1).
    // The 1..32 range then fits the 5-bit edge counter exactly.
    logic [4:0]              prescale_m1_reg;
    logic [4:0]              edge_cnt_reg;
    logic [IDX_W-1:0]        bit_idx_reg;
    logic                    tx_out_reg;
    logic                    busy_reg;

    logic [4:0]              prescale_m1_next;
    logic [IDX_W-1:0]        bit_idx_next;
    logic                    bit_end;
    logic                    last_bit;
    logic                    parity_bit;

    // Convert the raw Prescale input into a terminal count for edge_cnt.
    // A value of 0 behaves as 1.
    // Out-of-range values above 32 saturate at 32 cycles per bit.
    // For 32, the low five bits are 0, and 0 - 1 wraps to 31 as intended.
    always_comb begin
        prescale_m1_next = 5'd0;
        if (Prescale == 6'd0) begin
            prescale_m1_next = 5'd0;
        end else if (Prescale > 6'd32) begin
            prescale_m1_next = 5'd31;
        end else begin
            prescale_m1_next = Prescale[4:0] - 5'd1;
        end
    end

    // Per-cycle decode of the bit timer, the data bit index and the parity bit.
    always_comb begin
        bit_end      = (edge_cnt_reg == prescale_m1_reg);
        last_bit     = (bit_idx_reg == LAST_IDX);
        bit_idx_next = bit_idx_reg + 1'b1;
        // Even parity makes the total number of ones even; odd parity inverts that bit.
        parity_bit   = (^data_reg) ^ par_typ_reg;
    end

    // Frame sequencer.
    // Outputs are computed one edge ahead, so each level appears exactly when
    // its state starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            data_reg        <= '0;
            par_en_reg      <= 1'b0;
            par_typ_reg     <= 1'b0;
            prescale_m1_reg <= 5'd0;
            edge_cnt_reg    <= 5'd0;
            bit_idx_reg     <= '0;
            tx_out_reg      <= 1'b1;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_out_reg   <= 1'b1;
                    busy_reg     <= 1'b0;
                    edge_cnt_reg <= 5'd0;
                    bit_idx_reg  <= '0;
                    if (Data_Valid) begin
                        // Capture everything the frame needs.
                        // The inputs are free to change from here on.
                        data_reg        <= P_DATA;
                        par_en_reg      <= PAR_EN;
                        par_typ_reg     <= PAR_TYP;
                        prescale_m1_reg <= prescale_m1_next;
                        state_reg       <= START;
                        tx_out_reg      <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        edge_cnt_reg <= 5'd0;
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA;
                        tx_out_reg   <= data_reg[0];
                    end else begin
                        edge_cnt_reg <= edge_cnt_reg + 5'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        edge_cnt_reg <= 5'd0;
                        if (last_bit) begin
                            bit_idx_reg <= '0;
                            if (par_en_reg) begin
                                state_reg  <= PARITY;
                                tx_out_reg <= parity_bit;
                            end else begin
                                state_reg  <= STOP;
                                tx_out_reg <= 1'b1;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_next;
                            tx_out_reg  <= data_reg[bit_idx_next];
                        end
                    end else begin
                        edge_cnt_reg <= edge_cnt_reg + 5'd1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        edge_cnt_reg <= 5'd0;
                        state_reg    <= STOP;
                        tx_out_reg   <= 1'b1;
                    end else begin
                        edge_cnt_reg <= edge_cnt_reg + 5'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        // Busy falls together with the end of the stop bit.
                        // The next accept can happen one cycle later, from IDLE.
                        edge_cnt_reg <= 5'd0;
                        state_reg    <= IDLE;
                        tx_out_reg   <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        edge_cnt_reg <= edge_cnt_reg + 5'd1;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    edge_cnt_reg <= 5'd0;
                    bit_idx_reg  <= '0;
                    tx_out_reg   <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_out_reg;
    assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Testbench for uart_tx_frame_serializer.
// A table of frames with hand-derived busy length and parity bit.
// Hand-written corner sequences: ignored strobe, back-to-back frames, reset abort.
// Randomized frames.
// All waveforms are compared against a bit-list reference model.

module tb_uart_tx_frame_serializer;

    localparam int DW   = 8;
    localparam int MAXS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    Prescale;
    logic          TX_OUT;
    logic          Busy;

    always #5 clk = ~clk;

    uart_tx_frame_serializer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    int checks = 0;
    int errors = 0;

    logic cap_tx   [MAXS];
    logic cap_busy [MAXS];
    logic exp_tx   [MAXS];
    logic exp_busy [MAXS];

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        int         presc;
        int         busy_cyc;
        bit         par_bit;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int eff_p(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int frame_len(input bit pe, input int p);
        return (10 + int'(pe)) * eff_p(p);
    endfunction

    // Reference model: the idle line is high and not busy.
    task automatic model_clear();
        for (int i = 0; i < MAXS; i++) begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
        end
    endtask

    // Reference model: the frame is a list of bit levels, each repeated P times.
    // Sample 'start' is the first cycle after the accepting edge.
    task automatic model_frame(input int start, input logic [7:0] d, input bit pe,
                               input bit pt, input int p);
        int pp;
        bit bits[$];
        int ones;
        pp = eff_p(p);
        bits.push_back(1'b0);
        ones = 0;
        for (int b = 0; b < DW; b++) begin
            bits.push_back(d[b]);
            if (d[b]) ones++;
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size() * pp; k++) begin
            if (start + k < MAXS) begin
                exp_tx[start + k]   = bits[k / pp];
                exp_busy[start + k] = 1'b1;
            end
        end
    endtask

    // Present a request at a falling edge, then return right after the accepting rising edge.
    task automatic start_req(input logic [7:0] d, input bit pe, input bit pt, input int p);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = 6'(p);
        Data_Valid = 1'b1;
        @(posedge clk);
    endtask

    // Sample the outputs at each falling edge.
    // Unless hold is set, drop the strobe after the first sample and scramble the
    // config inputs, so that the latching of the config is exercised.
    // on_idx raises a strobe with on_data. off_idx drops it again.
    task automatic capture(input int len, input bit hold, input int on_idx,
                           input logic [7:0] on_data, input int off_idx);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cap_tx[i]   = TX_OUT;
            cap_busy[i] = Busy;
            if (i == 0 && !hold) begin
                Data_Valid = 1'b0;
                P_DATA     = 8'($urandom);
                Prescale   = 6'($urandom_range(1, 32));
                PAR_EN     = 1'($urandom);
                PAR_TYP    = 1'($urandom);
            end
            if (i == on_idx) begin
                Data_Valid = 1'b1;
                P_DATA     = on_data;
            end
            if (i == off_idx) Data_Valid = 1'b0;
        end
    endtask

    task automatic compare_wave(input string name, input int len);
        int bad;
        bad = -1;
        for (int i = 0; i < len; i++) begin
            if (bad < 0 && (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i])) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: cycle %0d TX_OUT=%0b Busy=%0b, expected TX_OUT=%0b Busy=%0b",
                     name, bad, cap_tx[bad], cap_busy[bad], exp_tx[bad], exp_busy[bad]);
        end
    endtask

    function automatic int busy_run();
        int n;
        n = 0;
        while (n < MAXS && cap_busy[n] === 1'b1) n++;
        return n;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int flen;
        flen = frame_len(v.pe, v.presc);
        model_clear();
        model_frame(0, v.data, v.pe, v.pt, v.presc);
        start_req(v.data, v.pe, v.pt, v.presc);
        capture(flen + 3, 1'b0, -1, 8'h00, -1);
        compare_wave({name, "_wave"}, flen + 3);
        check({name, "_busy_len"}, busy_run(), v.busy_cyc);
        if (v.pe) check({name, "_parity"}, int'(cap_tx[9 * eff_p(v.presc)]), int'(v.par_bit));
        $display("frame %s data=%02h pe=%0b pt=%0b P=%0d", name, v.data, v.pe, v.pt, v.presc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   base;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8,  80,  1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 4,  44,  1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 4,  44,  1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 32, 352, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 1,  11,  1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 0,  10,  1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 3,  33,  1'b1};

        rst        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(TX_OUT), 1);
        check("reset_busy", int'(Busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_tx", int'(TX_OUT), 1);

        // Table-driven frames
        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // A strobe while Busy is dropped; no second frame appears.
        model_clear();
        model_frame(0, 8'h3C, 1'b0, 1'b0, 4);
        start_req(8'h3C, 1'b0, 1'b0, 4);
        capture(70, 1'b0, 19, 8'hFF, 20);
        compare_wave("ignored_strobe", 70);
        $display("frame ignored_strobe data=3c then strobe ff at cycle 20");

        // Data_Valid held high: frames repeat every 10*P+1 cycles.
        model_clear();
        for (int f = 0; f < 3; f++) model_frame(f * 21, 8'h55, 1'b0, 1'b0, 2);
        start_req(8'h55, 1'b0, 1'b0, 2);
        capture(75, 1'b1, -1, 8'h00, 62);
        compare_wave("back_to_back", 75);
        check("b2b_gap", int'(cap_tx[20]) + int'(!cap_busy[20]), 2);
        $display("frame back_to_back data=55 P=2 x3");

        // Reset during data bit 3 aborts the frame on the next edge.
        model_clear();
        model_frame(0, 8'hC3, 1'b0, 1'b0, 4);
        start_req(8'hC3, 1'b0, 1'b0, 4);
        capture(18, 1'b0, -1, 8'h00, -1);
        compare_wave("pre_reset", 18);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", int'(TX_OUT), 1);
        check("abort_busy", int'(Busy), 0);
        rst = 1'b0;
        model_clear();
        capture(6, 1'b1, -1, 8'h00, -1);
        compare_wave("post_reset_idle", 6);
        v = '{8'h81, 1'b0, 1'b0, 4, 40, 1'b0};
        run_vec("after_reset", v);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            v.data     = 8'($urandom);
            v.pe       = 1'($urandom);
            v.pt       = 1'($urandom);
            v.presc    = $urandom_range(0, 6);
            base       = frame_len(v.pe, v.presc);
            v.busy_cyc = base;
            v.par_bit  = (^v.data) ^ v.pt;
            run_vec($sformatf("rand%0d", r), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
